mm3_seq: RTL and testbench

Sequential 3x3 unsigned matrix-multiply engine that sits directly upstream of the existing MULTIPLIER and feeds it operand pairs. It accepts matrices A and B as a stream of 18 elements, walks i/j/k with a single shared MULTIPLIER instance, accumulates each dot product, and emits the nine elements of C = A*B over a valid/ready output. It is the control and accumulation stage around the combinational multiplier.

---
 rtl/mm3_pkg.sv | 22 ++
 rtl/mm3_seq_if.sv | 28 ++
 rtl/mm3_seq_mult.sv | 19 +
 rtl/mm3_seq.sv | 162 ++++++++++++++++
 tb/tb_mm3_seq.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/mm3_pkg.sv
// Shared types and helpers for the mm3_seq 3x3 matrix-multiply engine.
package mm3_pkg;

  localparam int unsigned N     = 3;
  localparam int unsigned ELEMS = 18;

  typedef enum logic [1:0] {
    S_LOAD,
    S_CALC,
    S_EMIT
  } state_t;

  // Room for the largest dot product 3*(2^w-1)^2.
  function automatic int unsigned acc_w(input int unsigned w);
    return 2 * w + 2;
  endfunction

  function automatic logic [3:0] rm_idx(input logic [1:0] row, input logic [1:0] col);
    return ({2'b00, row} * 4'(N)) + {2'b00, col};
  endfunction

endpackage

// File: rtl/mm3_seq_if.sv
// Stream-in / stream-out bundle for mm3_seq; slave modport is the engine side.
interface mm3_seq_if
  import mm3_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned ACC_W = acc_w(WIDTH)
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_data;
  logic [3:0]       out_idx;
  logic             busy;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_idx, busy
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_idx, busy
  );

endinterface

// File: rtl/mm3_seq_mult.sv
// MULTIPLIER: combinational unsigned shift-and-add multiplier, one partial product per bit of i_b.
module MULTIPLIER #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic [2*WIDTH-1:0] o_prod
);

  always_comb begin
    o_prod = '0;
    for (int unsigned n = 0; n < WIDTH; n++) begin
      if (i_b[n]) begin
        o_prod = o_prod + (((2*WIDTH)'(i_a)) << n);
      end
    end
  end

endmodule

// File: rtl/mm3_seq.sv
// Sequential 3x3 matrix multiply around a single MULTIPLIER.
// Define MM3_PROD_REG_EN to register the product ahead of the accumulator.
module mm3_seq
  import mm3_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned ACC_W = acc_w(WIDTH)
) (
  input logic     clk,
  input logic     rst,
  mm3_seq_if.slave bus
);

  if (WIDTH != 4) begin : g_width_chk
    $error("mm3_seq: WIDTH must be 4");
  end
  if (ACC_W < acc_w(WIDTH)) begin : g_accw_chk
    $error("mm3_seq: ACC_W too narrow");
  end

  state_t             r_state;
  logic [4:0]         r_load_cnt;
  logic [1:0]         r_i;
  logic [1:0]         r_j;
  logic [1:0]         r_k;
  logic [ACC_W-1:0]   r_acc;
  logic [ACC_W-1:0]   r_out_data;
  logic [3:0]         r_out_idx;
  logic               r_out_valid;
  logic               r_in_ready;
  logic               r_busy;

  logic [WIDTH-1:0]   r_mat_a [9];
  logic [WIDTH-1:0]   r_mat_b [9];

  logic [1:0]         w_mul_k;
  logic [WIDTH-1:0]   w_a;
  logic [WIDTH-1:0]   w_b;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_addend;
  logic               w_acc_en;
  logic [ACC_W-1:0]   w_sum;

  // Matrix storage is deliberately left without reset.
  always_ff @(posedge clk) begin
    if (r_state == S_LOAD && bus.in_valid) begin
      if (r_load_cnt < 5'(N*N)) begin
        r_mat_a[r_load_cnt[3:0]] <= bus.in_data;
      end else begin
        r_mat_b[4'(r_load_cnt - 5'(N*N))] <= bus.in_data;
      end
    end
  end

  assign w_mul_k = (r_k == 2'd3) ? 2'd0 : r_k;
  assign w_a     = r_mat_a[rm_idx(r_i, w_mul_k)];
  assign w_b     = r_mat_b[rm_idx(w_mul_k, r_j)];

  MULTIPLIER #(.WIDTH(WIDTH)) u_mult (
    .i_a    (w_a),
    .i_b    (w_b),
    .o_prod (w_prod)
  );

`ifdef MM3_PROD_REG_EN
  // k counts 0..3: k=0 only fills r_prod, k=1..3 accumulate the product of k-1.
  localparam logic [1:0] K_LAST = 2'd3;
  logic [2*WIDTH-1:0] r_prod;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prod <= '0;
    end else if (r_state == S_CALC) begin
      r_prod <= w_prod;
    end
  end

  assign w_addend = r_prod;
  assign w_acc_en = (r_k != 2'd0);
`else
  localparam logic [1:0] K_LAST = 2'd2;
  assign w_addend = w_prod;
  assign w_acc_en = 1'b1;
`endif

  assign w_sum = r_acc + ACC_W'(w_addend);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_LOAD;
      r_load_cnt  <= '0;
      r_i         <= '0;
      r_j         <= '0;
      r_k         <= '0;
      r_acc       <= '0;
      r_out_data  <= '0;
      r_out_idx   <= '0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_LOAD: begin
          if (bus.in_valid) begin
            r_load_cnt <= r_load_cnt + 5'd1;
            if (r_load_cnt == 5'(ELEMS - 1)) begin
              r_state    <= S_CALC;
              r_in_ready <= 1'b0;
              r_busy     <= 1'b1;
              r_i        <= '0;
              r_j        <= '0;
              r_k        <= '0;
              r_acc      <= '0;
            end
          end
        end
        S_CALC: begin
          if (w_acc_en) begin
            r_acc <= w_sum;
          end
          if (r_k == K_LAST) begin
            r_out_data  <= w_sum;
            r_out_idx   <= rm_idx(r_i, r_j);
            r_out_valid <= 1'b1;
            r_state     <= S_EMIT;
          end else begin
            r_k <= r_k + 2'd1;
          end
        end
        S_EMIT: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            if (r_out_idx == 4'd8) begin
              r_state    <= S_LOAD;
              r_load_cnt <= '0;
              r_in_ready <= 1'b1;
              r_busy     <= 1'b0;
            end else begin
              if (r_j == 2'd2) begin
                r_j <= '0;
                r_i <= r_i + 2'd1;
              end else begin
                r_j <= r_j + 2'd1;
              end
              r_k     <= '0;
              r_acc   <= '0;
              r_state <= S_CALC;
            end
          end
        end
        default: r_state <= S_LOAD;
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_idx   = r_out_idx;
  assign bus.busy      = r_busy;

endmodule

// File: tb/tb_mm3_seq.sv
// Directed self-checking bench for mm3_seq (both MM3_PROD_REG_EN builds).
module tb_mm3_seq;

`ifdef MM3_PROD_REG_EN
  localparam int LAT = 4;
  localparam int SPC = 5;
`else
  localparam int LAT = 3;
  localparam int SPC = 4;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  mm3_seq_if #(.WIDTH(4)) bus ();

  mm3_seq #(.WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [9:0]  obs_data [9];
  logic [3:0]  obs_idx  [9];
  int          obs_gap  [9];
  bit          obs_timeout;
  logic [16:0] snap [6];
  logic [2:0]  obs_post;

  // Element 0 sits in the top nibble.
  task automatic load(input logic [35:0] a, input logic [35:0] b);
    for (int e = 0; e < 18; e++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = (e < 9) ? a[35-4*e -: 4] : b[35-4*(e-9) -: 4];
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
  endtask

  // Gathers nine outputs with out_ready high, optionally stalling one element.
  task automatic collect(input int stall_idx, input bit garbage);
    int cnt;
    int n;
    n = 0;
    cnt = 0;
    obs_timeout = 1'b0;
    for (int q = 0; q < 9; q++) begin
      obs_data[q] = 'x;
      obs_idx[q]  = 'x;
      obs_gap[q]  = -1;
    end
    bus.out_ready = 1'b1;
    while (n < 9 && !obs_timeout) begin
      @(posedge clk); #1;
      cnt++;
      if (garbage) begin
        bus.in_valid = 1'($urandom_range(0, 1));
        bus.in_data  = 4'($urandom);
      end
      if (bus.out_valid) begin
        obs_data[n] = bus.out_data;
        obs_idx[n]  = bus.out_idx;
        obs_gap[n]  = cnt;
        cnt = 0;
        if (n == stall_idx) begin
          bus.out_ready = 1'b0;
          for (int s = 0; s < 6; s++) begin
            @(posedge clk); #1;
            snap[s] = {bus.out_valid, bus.in_ready, bus.busy, bus.out_idx, bus.out_data};
          end
          bus.out_ready = 1'b1;
        end
        n++;
      end else if (cnt > 40) begin
        obs_timeout = 1'b1;
      end
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    obs_post = {bus.in_ready, bus.busy, bus.out_valid};
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got=%b exp=0", bus.out_valid); end
    n_tests++; if (bus.out_data !== 10'd0) begin n_fail++; $display("FAIL rst_out_data got=%0d exp=0", bus.out_data); end
    n_tests++; if (bus.out_idx !== 4'd0) begin n_fail++; $display("FAIL rst_out_idx got=%0d exp=0", bus.out_idx); end
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got=%b exp=0", bus.busy); end
    n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready got=%b exp=1", bus.in_ready); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_identity();
    load(36'h100010001, 36'h123456789);
    collect(-1, 1'b0);
    n_tests++; if (obs_timeout) begin n_fail++; $display("FAIL ident_timeout got=1 exp=0"); end
    for (int n = 0; n < 9; n++) begin
      n_tests++; if (obs_data[n] !== 10'(n + 1)) begin n_fail++; $display("FAIL ident_data[%0d] got=%0d exp=%0d", n, obs_data[n], n + 1); end
      n_tests++; if (obs_idx[n] !== 4'(n)) begin n_fail++; $display("FAIL ident_idx[%0d] got=%0d exp=%0d", n, obs_idx[n], n); end
      n_tests++; if (obs_gap[n] !== ((n == 0) ? LAT : SPC)) begin n_fail++; $display("FAIL ident_gap[%0d] got=%0d exp=%0d", n, obs_gap[n], (n == 0) ? LAT : SPC); end
    end
    n_tests++; if (obs_post !== 3'b100) begin n_fail++; $display("FAIL ident_post got=%b exp=100", obs_post); end
  endtask

  task automatic test_max();
    load(36'hFFFFFFFFF, 36'hFFFFFFFFF);
    collect(-1, 1'b0);
    for (int n = 0; n < 9; n++) begin
      n_tests++; if (obs_data[n] !== 10'h2A3) begin n_fail++; $display("FAIL max_data[%0d] got=%0d exp=675", n, obs_data[n]); end
      n_tests++; if (obs_idx[n] !== 4'(n)) begin n_fail++; $display("FAIL max_idx[%0d] got=%0d exp=%0d", n, obs_idx[n], n); end
    end
  endtask

  task automatic test_mixed();
    logic [9:0] exp_c [9];
    exp_c = '{10'd30, 10'd24, 10'd18, 10'd84, 10'd69, 10'd54, 10'd138, 10'd114, 10'd90};
    load(36'h123456789, 36'h987654321);
    collect(-1, 1'b0);
    for (int n = 0; n < 9; n++) begin
      n_tests++; if (obs_data[n] !== exp_c[n]) begin n_fail++; $display("FAIL mixed_data[%0d] got=%0d exp=%0d", n, obs_data[n], exp_c[n]); end
    end
  endtask

  task automatic test_backpressure();
    logic [9:0] exp_c [9];
    exp_c = '{10'd30, 10'd24, 10'd18, 10'd84, 10'd69, 10'd54, 10'd138, 10'd114, 10'd90};
    load(36'h123456789, 36'h987654321);
    collect(4, 1'b0);
    for (int s = 0; s < 6; s++) begin
      n_tests++; if (snap[s] !== {1'b1, 1'b0, 1'b1, 4'd4, 10'd69}) begin n_fail++; $display("FAIL bp_hold[%0d] got=%h exp=%h", s, snap[s], {1'b1, 1'b0, 1'b1, 4'd4, 10'd69}); end
    end
    for (int n = 0; n < 9; n++) begin
      n_tests++; if (obs_data[n] !== exp_c[n] || obs_idx[n] !== 4'(n)) begin n_fail++; $display("FAIL bp_out[%0d] got=%0d/%0d exp=%0d/%0d", n, obs_data[n], obs_idx[n], exp_c[n], n); end
    end
    n_tests++; if (obs_gap[5] !== SPC) begin n_fail++; $display("FAIL bp_gap5 got=%0d exp=%0d", obs_gap[5], SPC); end
  endtask

  task automatic test_reset_mid();
    bit found;
    found = 1'b0;
    load(36'h100010001, 36'h123456789);
    bus.out_ready = 1'b1;
    for (int c = 0; c < 40 && !found; c++) begin
      @(posedge clk); #1;
      if (bus.out_valid && bus.out_idx == 4'd1) found = 1'b1;
    end
    n_tests++; if (!found) begin n_fail++; $display("FAIL rmid_reach_idx1 got=0 exp=1"); end
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_tests++; if ({bus.busy, bus.out_valid} !== 2'b10) begin n_fail++; $display("FAIL rmid_in_calc got=%b exp=10", {bus.busy, bus.out_valid}); end
    rst = 1'b1;
    #1;
    n_tests++; if ({bus.out_valid, bus.in_ready, bus.busy} !== 3'b010) begin n_fail++; $display("FAIL rmid_async got=%b exp=010", {bus.out_valid, bus.in_ready, bus.busy}); end
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    load(36'h100010001, 36'h100010001);
    collect(-1, 1'b0);
    for (int n = 0; n < 9; n++) begin
      n_tests++; if (obs_data[n] !== ((n % 4 == 0) ? 10'd1 : 10'd0)) begin n_fail++; $display("FAIL rmid_data[%0d] got=%0d exp=%0d", n, obs_data[n], (n % 4 == 0) ? 1 : 0); end
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] exp_c [9];
    exp_c = '{10'd30, 10'd24, 10'd18, 10'd84, 10'd69, 10'd54, 10'd138, 10'd114, 10'd90};
    load(36'h123456789, 36'h987654321);
    collect(-1, 1'b1);
    for (int n = 0; n < 9; n++) begin
      n_tests++; if (obs_data[n] !== exp_c[n]) begin n_fail++; $display("FAIL b2b_garbage_data[%0d] got=%0d exp=%0d", n, obs_data[n], exp_c[n]); end
    end
    n_tests++; if (obs_post !== 3'b100) begin n_fail++; $display("FAIL b2b_ready_after got=%b exp=100", obs_post); end
    load(36'h100010001, 36'h123456789);
    collect(-1, 1'b0);
    for (int n = 0; n < 9; n++) begin
      n_tests++; if (obs_data[n] !== 10'(n + 1) || obs_idx[n] !== 4'(n)) begin n_fail++; $display("FAIL b2b_second[%0d] got=%0d/%0d exp=%0d/%0d", n, obs_data[n], obs_idx[n], n + 1, n); end
    end
    n_tests++; if (obs_gap[0] !== LAT) begin n_fail++; $display("FAIL b2b_latency got=%0d exp=%0d", obs_gap[0], LAT); end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_identity();
    test_max();
    test_mixed();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
